// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: FSM encodings, access size
// codes, the default I/O region tag and the size-to-last-byte helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // addr[17:16] value that selects the memory-mapped I/O window (UART)
    localparam logic [1:0] IO_REGION_HI = 2'b11;

    // Index of the last byte of an access; unknown codes are treated as a word
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 2'd0;
            SIZE_HALF: return 2'd1;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester-side bus of the memory controller: instruction fetch port and
// load/store port. The CPU pipeline is the master, mem_ctrl the slave.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_data;

    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    modport master (
        output if_req, if_addr, if_flush,
        output ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        input  if_done, if_data, ls_done, ls_rdata
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        output if_done, if_data, ls_done, ls_rdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store
// onto an 8-bit RAM port. One byte per cycle, round-robin arbitration, a
// mandatory idle bubble after every done pulse, and flow control on writes
// into the I/O window.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_HI = IO_REGION_HI
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    mem_ctrl_if.slave   bus
);

    state_t      state_reg;
    logic [1:0]  idx_reg;
    logic [1:0]  last_idx_reg;
    logic [31:0] base_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rbuf_reg;
    logic [31:0] mem_a_reg;
    logic [7:0]  mem_dout_reg;
    logic        mem_wr_reg;
    logic        owner_ls_reg;   // current transaction belongs to load/store
    logic        last_ls_reg;    // round-robin pointer: 1 = LS granted last
    logic        if_done_reg;
    logic        ls_done_reg;
    logic [31:0] if_data_reg;
    logic [31:0] ls_rdata_reg;

    logic        done_bubble;
    logic        if_elig;
    logic        grant_ls;
    logic        grant_if;
    logic        io_blk;
    logic        at_last;
    logic [1:0]  idx_next;
    logic [31:0] addr_next;
    logic [7:0]  byte_next;
    logic [31:0] read_word;

    // Requesters still hold req during the done cycle, so no grant then
    assign done_bubble = if_done_reg | ls_done_reg;
    assign if_elig     = bus.if_req & ~bus.if_flush;
    assign grant_ls    = ~done_bubble & bus.ls_req & (~if_elig | ~last_ls_reg);
    assign grant_if    = ~done_bubble & if_elig & ~grant_ls;

    // A write byte aimed at the I/O window waits while the UART buffer is full
    assign io_blk    = (state_reg == ST_WRITE) && (mem_a_reg[17:16] == IO_HI)
                       && io_buffer_full;
    assign at_last   = (idx_reg == last_idx_reg);
    assign idx_next  = idx_reg + 2'd1;
    assign addr_next = base_reg + {30'd0, idx_next};
    assign byte_next = wdata_reg[{idx_next, 3'b000} +: 8];
    assign read_word = rbuf_reg | ({24'd0, mem_din} << {idx_reg, 3'b000});

    assign mem_a        = mem_a_reg;
    assign mem_dout     = mem_dout_reg;
    assign mem_wr       = mem_wr_reg & rdy_in & ~io_blk;
    assign bus.if_done  = if_done_reg;
    assign bus.if_data  = if_data_reg;
    assign bus.ls_done  = ls_done_reg;
    assign bus.ls_rdata = ls_rdata_reg;

    // Arbitration, byte sequencing and result registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 2'd0;
            last_idx_reg <= 2'd0;
            base_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            rbuf_reg     <= 32'd0;
            mem_a_reg    <= 32'd0;
            mem_dout_reg <= 8'd0;
            mem_wr_reg   <= 1'b0;
            owner_ls_reg <= 1'b0;
            last_ls_reg  <= 1'b0;
            if_done_reg  <= 1'b0;
            ls_done_reg  <= 1'b0;
            if_data_reg  <= 32'd0;
            ls_rdata_reg <= 32'd0;
        end else if (rdy_in) begin
            if_done_reg <= 1'b0;
            ls_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    mem_wr_reg <= 1'b0;
                    idx_reg    <= 2'd0;
                    rbuf_reg   <= 32'd0;
                    if (grant_ls) begin
                        owner_ls_reg <= 1'b1;
                        last_ls_reg  <= 1'b1;
                        base_reg     <= bus.ls_addr;
                        mem_a_reg    <= bus.ls_addr;
                        last_idx_reg <= last_index(bus.ls_size);
                        wdata_reg    <= bus.ls_wdata;
                        mem_dout_reg <= bus.ls_wdata[7:0];
                        if (bus.ls_wr) begin
                            state_reg  <= ST_WRITE;
                            mem_wr_reg <= 1'b1;
                        end else begin
                            state_reg  <= ST_READ;
                        end
                    end else if (grant_if) begin
                        owner_ls_reg <= 1'b0;
                        last_ls_reg  <= 1'b0;
                        base_reg     <= bus.if_addr;
                        mem_a_reg    <= bus.if_addr;
                        last_idx_reg <= 2'd3;
                        state_reg    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!owner_ls_reg && bus.if_flush) begin
                        state_reg <= ST_IDLE;
                    end else if (at_last) begin
                        state_reg <= ST_IDLE;
                        if (owner_ls_reg) begin
                            ls_rdata_reg <= read_word;
                            ls_done_reg  <= 1'b1;
                        end else begin
                            if_data_reg  <= read_word;
                            if_done_reg  <= 1'b1;
                        end
                    end else begin
                        rbuf_reg  <= read_word;
                        idx_reg   <= idx_next;
                        mem_a_reg <= addr_next;
                    end
                end
                ST_WRITE: begin
                    if (!io_blk) begin
                        if (at_last) begin
                            state_reg   <= ST_IDLE;
                            mem_wr_reg  <= 1'b0;
                            ls_done_reg <= 1'b1;
                        end else begin
                            idx_reg      <= idx_next;
                            mem_a_reg    <= addr_next;
                            mem_dout_reg <= byte_next;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed transactions push expected
// responses (fetched words, load data, RAM byte writes) into queues; a
// monitor compares every done pulse and RAM write against them.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Read data for the address presented this cycle is sampled at the next edge
    logic [7:0] ram [0:4095];
    assign mem_din = ram[mem_a[11:0]];

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_exp_t;

    typedef struct {
        bit          chk;
        logic [31:0] d;
    } ls_exp_t;

    wr_exp_t     exp_wr[$];
    ls_exp_t     exp_ls[$];
    logic [31:0] exp_if[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ls_done_cyc = 0;
    int if_done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic monitor_step();
        wr_exp_t w;
        ls_exp_t l;
        if (bus.if_done === 1'b1) begin
            if_done_cyc = cyc;
            if (exp_if.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL if_done_unexpected: if_data 0x%08h, no fetch outstanding", bus.if_data);
            end else begin
                check("if_data", bus.if_data, exp_if.pop_front());
            end
        end
        if (bus.ls_done === 1'b1) begin
            ls_done_cyc = cyc;
            if (exp_ls.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL ls_done_unexpected: ls_rdata 0x%08h, no access outstanding", bus.ls_rdata);
            end else begin
                l = exp_ls.pop_front();
                if (l.chk) begin
                    check("ls_rdata", bus.ls_rdata, l.d);
                end else begin
                    n_checks++;
                    $display("ok   ls_done store complete");
                end
            end
        end
        if (mem_wr === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL wr_unexpected: write 0x%02h at 0x%08h, none expected", mem_dout, mem_a);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", mem_a, w.a);
                check("wr_data", {24'd0, mem_dout}, {24'd0, w.d});
            end
        end
    endtask

    task automatic wait_ls(input int bound, output int k);
        k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (bus.ls_done !== 1'b1 && k < bound);
        if (bus.ls_done !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL ls_done_timeout: none in %0d cycles, expected a pulse", bound);
        end
    endtask

    task automatic wait_if(input int bound, output int k);
        k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (bus.if_done !== 1'b1 && k < bound);
        if (bus.if_done !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL if_done_timeout: none in %0d cycles, expected a pulse", bound);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k1, k2;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = 2'd0;
        bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;

        fork
            forever begin
                @(negedge clk_in);
                monitor_step();
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_if_done", {31'd0, bus.if_done}, 32'd0);
        check("rst_ls_done", {31'd0, bus.ls_done}, 32'd0);
        check("rst_if_data", bus.if_data, 32'd0);
        check("rst_ls_rdata", bus.ls_rdata, 32'd0);
        step();

        // Fetch 0x1000: bytes 13 00 00 00, done in cycle after E0+4
        ram[12'h000] = 8'h13; ram[12'h001] = 8'h00; ram[12'h002] = 8'h00; ram[12'h003] = 8'h00;
        exp_if.push_back(32'h0000_0013);
        bus.if_addr = 32'h0000_1000; bus.if_req = 1'b1;
        step();
        wait_if(20, k);
        check("if_latency", k, 5);
        step(); bus.if_req = 1'b0;
        step();

        // Word store 0xDEADBEEF at 0x20
        exp_wr.push_back('{32'h20, 8'hEF});
        exp_wr.push_back('{32'h21, 8'hBE});
        exp_wr.push_back('{32'h22, 8'hAD});
        exp_wr.push_back('{32'h23, 8'hDE});
        exp_ls.push_back('{1'b0, 32'd0});
        bus.ls_wr = 1'b1; bus.ls_size = 2'd2; bus.ls_addr = 32'h20; bus.ls_wdata = 32'hDEAD_BEEF;
        bus.ls_req = 1'b1;
        step();
        wait_ls(20, k);
        check("st_latency", k, 5);
        step(); bus.ls_req = 1'b0;
        step();

        // Both requests right after reset: LS first, IF after the bubble
        rst_in = 1'b1;
        step(); rst_in = 1'b0;
        ram[12'h100] = 8'h01; ram[12'h101] = 8'h02; ram[12'h102] = 8'h03; ram[12'h103] = 8'h04;
        ram[12'h200] = 8'hA0; ram[12'h201] = 8'hB1; ram[12'h202] = 8'hC2; ram[12'h203] = 8'hD3;
        exp_ls.push_back('{1'b1, 32'h0403_0201});
        exp_if.push_back(32'hD3C2_B1A0);
        bus.ls_wr = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h100; bus.ls_req = 1'b1;
        bus.if_addr = 32'h200; bus.if_req = 1'b1;
        step();
        fork
            begin
                wait_ls(30, k1);
                step(); bus.ls_req = 1'b0;
            end
            begin
                wait_if(30, k2);
                step(); bus.if_req = 1'b0;
            end
        join
        check("arb_ls_latency", k1, 5);
        check("arb_if_latency", k2, 11);
        check("arb_gap", if_done_cyc - ls_done_cyc, 6);
        step();

        // Byte store into the I/O window, UART full for 3 cycles
        exp_wr.push_back('{32'h0003_0000, 8'h41});
        exp_ls.push_back('{1'b0, 32'd0});
        io_buffer_full = 1'b1;
        bus.ls_wr = 1'b1; bus.ls_size = 2'd0; bus.ls_addr = 32'h0003_0000;
        bus.ls_wdata = 32'h1234_5641; bus.ls_req = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("io_hold_wr", {31'd0, mem_wr}, 32'd0);
        end
        step(); io_buffer_full = 1'b0;
        wait_ls(20, k);
        check("io_latency", k, 2);
        step(); bus.ls_req = 1'b0;
        step();

        // Flush at E0+2 of a fetch; pending half load granted at E0+3
        ram[12'h040] = 8'hAA; ram[12'h041] = 8'hBB;
        exp_ls.push_back('{1'b1, 32'h0000_BBAA});
        bus.if_addr = 32'h300; bus.if_req = 1'b1;
        bus.ls_wr = 1'b0; bus.ls_size = 2'd1; bus.ls_addr = 32'h40; bus.ls_req = 1'b1;
        step();
        step(); bus.if_flush = 1'b1;
        step(); bus.if_flush = 1'b0; bus.if_req = 1'b0;
        wait_ls(20, k);
        check("flush_ls_latency", k, 4);
        step(); bus.ls_req = 1'b0;
        step();

        // Word load with rdy_in low for two cycles mid-transfer
        ram[12'h050] = 8'h11; ram[12'h051] = 8'h22; ram[12'h052] = 8'h33; ram[12'h053] = 8'h44;
        exp_ls.push_back('{1'b1, 32'h4433_2211});
        bus.ls_wr = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h50; bus.ls_req = 1'b1;
        step();
        step(); rdy_in = 1'b0;
        step();
        step(); rdy_in = 1'b1;
        wait_ls(20, k);
        check("stall_latency", k, 4);
        step(); bus.ls_req = 1'b0;
        step();

        // Word load across the 32-bit address wrap
        ram[12'hFFE] = 8'h5A; ram[12'hFFF] = 8'h6B; ram[12'h000] = 8'h7C; ram[12'h001] = 8'h8D;
        exp_ls.push_back('{1'b1, 32'h8D7C_6B5A});
        bus.ls_wr = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'hFFFF_FFFE; bus.ls_req = 1'b1;
        step();
        @(negedge clk_in);
        check("wrap_addr0", mem_a, 32'hFFFF_FFFE);
        @(negedge clk_in);
        @(negedge clk_in);
        check("wrap_addr2", mem_a, 32'h0000_0000);
        wait_ls(20, k);
        check("wrap_latency", k, 2);
        step(); bus.ls_req = 1'b0;
        step();

        // Reset at E0+1 of a word store: only byte 0 lands, no done
        exp_wr.push_back('{32'h400, 8'h44});
        bus.ls_wr = 1'b1; bus.ls_size = 2'd2; bus.ls_addr = 32'h400;
        bus.ls_wdata = 32'h1122_3344; bus.ls_req = 1'b1;
        step();
        rst_in = 1'b1;
        step(); rst_in = 1'b0; bus.ls_req = 1'b0;
        @(negedge clk_in);
        check("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mid_ls_done", {31'd0, bus.ls_done}, 32'd0);
        check("rst_mid_ls_rdata", bus.ls_rdata, 32'd0);
        check("rst_mid_mem_a", mem_a, 32'd0);
        repeat (6) step();

        check("left_if", exp_if.size(), 0);
        check("left_ls", exp_ls.size(), 0);
        check("left_wr", exp_wr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
